// File: rtl/issue_unit.sv
// ----------------------------------------------------------------------------
// issue_unit
//
// Issue arbiter on the consumer side of the issue queues. It looks at the
// ready flags from the integer, load/store, multiply and divide queues and
// returns at most one same-cycle grant. A unit is granted only if its result
// is guaranteed a free common-data-bus (CDB) slot when it completes. The
// block tracks future CDB reservations and whether the non-pipelined divider
// is busy.
//
// Optional feature (macro ISSUE_UNIT_STATS_EN):
//   When defined, two 32-bit wrapping statistics counters are added as
//   output ports: Stat_Issue_Cnt (cycles with a grant) and Stat_Stall_Cnt
//   (cycles with some ready queue but no grant, flush cycles excluded).
//
// Ports:
//   Clk                clock, rising edge
//   Rst                asynchronous, active-high reset
//   IssueInt_Ready     integer queue holds a ready instruction
//   IssueLsb_Ready     load/store queue holds a ready instruction
//   IssueMul_Ready     multiply queue holds a ready instruction
//   IssueDiv_Ready     divide queue holds a ready instruction
//   RB_Flush_Valid     flush in progress, no grants this cycle
//   Issueblk_IssueInt  grant to integer queue (combinational)
//   Issueblk_IssueLsb  grant to load/store queue (combinational)
//   Issueblk_IssueMul  grant to multiply queue (combinational)
//   Issueblk_IssueDiv  grant to divide queue (combinational)
//   Issue_Div_Busy     divider occupied
//   Stat_Issue_Cnt     grant counter (ISSUE_UNIT_STATS_EN only)
//   Stat_Stall_Cnt     stall counter (ISSUE_UNIT_STATS_EN only)
// ----------------------------------------------------------------------------
module issue_unit #(
    parameter int INT_LAT = 1,
    parameter int LSB_LAT = 1,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 6
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        IssueInt_Ready,
    input  logic        IssueLsb_Ready,
    input  logic        IssueMul_Ready,
    input  logic        IssueDiv_Ready,
    input  logic        RB_Flush_Valid,
    output logic        Issueblk_IssueInt,
    output logic        Issueblk_IssueLsb,
    output logic        Issueblk_IssueMul,
    output logic        Issueblk_IssueDiv,
    output logic        Issue_Div_Busy
`ifdef ISSUE_UNIT_STATS_EN
    ,
    output logic [31:0] Stat_Issue_Cnt,
    output logic [31:0] Stat_Stall_Cnt
`endif
);

    localparam int CNT_W = $clog2(DIV_LAT);

    // cdb_res[k] set means the CDB is already claimed k+1 cycles from now
    logic [DIV_LAT-1:0] cdb_res;
    logic [DIV_LAT-1:0] res_mask;
    logic [CNT_W-1:0]   div_cnt;
    logic               lru;

    logic int_ok;
    logic lsb_ok;
    logic mul_ok;
    logic div_ok;

    // A unit is eligible when its completion slot on the CDB is still free;
    // the divider additionally has to have finished its previous operation.
    assign int_ok = IssueInt_Ready & ~cdb_res[INT_LAT-1];
    assign lsb_ok = IssueLsb_Ready & ~cdb_res[LSB_LAT-1];
    assign mul_ok = IssueMul_Ready & ~cdb_res[MUL_LAT-1];
    assign div_ok = IssueDiv_Ready & ~cdb_res[DIV_LAT-1] & (div_cnt == '0);

    assign Issue_Div_Busy = (div_cnt != '0);

    // Fixed priority DIV > MUL > {INT, LSB}; the two single-cycle units
    // share the remaining slot by least-recently-granted. Reset gates the
    // grants combinationally so they drop the moment Rst rises. res_mask
    // marks the CDB slot the granted unit will occupy.
    always_comb begin
        Issueblk_IssueInt = 1'b0;
        Issueblk_IssueLsb = 1'b0;
        Issueblk_IssueMul = 1'b0;
        Issueblk_IssueDiv = 1'b0;
        res_mask          = '0;
        if (!Rst && !RB_Flush_Valid) begin
            if (div_ok) begin
                Issueblk_IssueDiv   = 1'b1;
                res_mask[DIV_LAT-1] = 1'b1;
            end else if (mul_ok) begin
                Issueblk_IssueMul   = 1'b1;
                res_mask[MUL_LAT-1] = 1'b1;
            end else if (int_ok && (!lru || !lsb_ok)) begin
                Issueblk_IssueInt   = 1'b1;
                res_mask[INT_LAT-1] = 1'b1;
            end else if (lsb_ok) begin
                Issueblk_IssueLsb   = 1'b1;
                res_mask[LSB_LAT-1] = 1'b1;
            end
        end
    end

    // Reservation window slides one slot per cycle. Flush deliberately does
    // not touch this state: operations already in flight still complete and
    // still need their CDB slots and the divider.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cdb_res <= '0;
            div_cnt <= '0;
            lru     <= 1'b0;
        end else begin
            cdb_res <= (cdb_res | res_mask) >> 1;
            if (Issueblk_IssueDiv) begin
                div_cnt <= CNT_W'(DIV_LAT - 1);
            end else if (div_cnt != '0) begin
                div_cnt <= div_cnt - 1'b1;
            end
            if (Issueblk_IssueInt) begin
                lru <= 1'b1;
            end else if (Issueblk_IssueLsb) begin
                lru <= 1'b0;
            end
        end
    end

`ifdef ISSUE_UNIT_STATS_EN
    logic any_ready;
    logic any_grant;

    assign any_ready = IssueInt_Ready | IssueLsb_Ready | IssueMul_Ready | IssueDiv_Ready;
    assign any_grant = Issueblk_IssueInt | Issueblk_IssueLsb | Issueblk_IssueMul | Issueblk_IssueDiv;

    // Counters wrap naturally at 2^32; a stall is a cycle where work was
    // waiting but nothing could go, not counting flush cycles.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Stat_Issue_Cnt <= '0;
            Stat_Stall_Cnt <= '0;
        end else begin
            if (any_grant) begin
                Stat_Issue_Cnt <= Stat_Issue_Cnt + 32'd1;
            end
            if (any_ready && !any_grant && !RB_Flush_Valid) begin
                Stat_Stall_Cnt <= Stat_Stall_Cnt + 32'd1;
            end
        end
    end
`else
    // Statistics counters are not present in this build.
`endif

endmodule
